// File: rtl/f2f_share_sched_if.sv
// Requester-side sample channel and consumer-side result channel of the shared fixed2float converter.
interface f2f_share_sched_if #(
    parameter int N_REQ   = 4,
    parameter int F_WIDTH = 43,
    parameter int TAG_W   = 2
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*F_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     res_valid;
    logic [15:0]              res_data;
    logic [TAG_W-1:0]         res_tag;
    logic                     res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/f2f_share_sched.sv
// Round-robin share of one fixed-latency fixed2float converter among N_REQ requesters, results via a tagged FIFO.
// Latency: accept to res_valid is CONV_LAT+1 cycles; 1 sample/cycle sustained while res_ready=1.
// Backpressure: issue is credit-gated on FIFO space plus in-flight samples, since the converter cannot stall.
module f2f_share_sched #(
    parameter int N_REQ      = 4,
    parameter int F_WIDTH    = 43,
    parameter int CONV_LAT   = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    f2f_share_sched_if.slave   bus,
    output logic [F_WIDTH-1:0] conv_fixed_in,
    input  logic [15:0]        conv_float_out,
    output logic               busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(CONV_LAT + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + CONV_LAT + 1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] win;
    logic             win_found;
    logic             issue;
    logic [OCC_W-1:0] occ;

    logic [CONV_LAT-1:0] dl_vld;
    logic [TAG_W-1:0]    dl_tag [CONV_LAT];
    logic [IF_W-1:0]     inflight;

    logic [15:0]      fifo_dat [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FC_W-1:0]  fifo_cnt;
    logic             push;
    logic             pop;

    // Everything already committed occupies a FIFO slot eventually, so credit covers both.
    assign occ   = OCC_W'(fifo_cnt) + OCC_W'(inflight);
    assign issue = reset_n && win_found && (occ < OCC_W'(FIFO_DEPTH));

    always_comb begin
        int idx;
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win       = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (issue) bus.req_ready[win] = 1'b1;
    end

    assign push          = dl_vld[CONV_LAT-1];
    assign bus.res_valid = (fifo_cnt != '0);
    assign pop           = bus.res_valid && bus.res_ready;
    assign bus.res_data  = bus.res_valid ? fifo_dat[rd_ptr] : 16'h0000;
    assign bus.res_tag   = bus.res_valid ? fifo_tag[rd_ptr] : '0;
    assign busy          = (inflight != '0) || bus.res_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            conv_fixed_in <= '0;
            dl_vld        <= '0;
            for (int s = 0; s < CONV_LAT; s++) dl_tag[s] <= '0;
            inflight      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
        end else begin
            conv_fixed_in <= issue ? bus.req_data[int'(win)*F_WIDTH +: F_WIDTH] : '0;
            dl_vld        <= {dl_vld[CONV_LAT-2:0], issue};
            dl_tag[0]     <= win;
            for (int s = 1; s < CONV_LAT; s++) dl_tag[s] <= dl_tag[s-1];
            if (issue) rr_ptr <= (win == TAG_W'(N_REQ - 1)) ? '0 : win + TAG_W'(1);
            case ({issue, push})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + FC_W'(push) - FC_W'(pop);
        end
    end

    // Storage needs no reset: head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_dat[wr_ptr] <= conv_float_out;
            fifo_tag[wr_ptr] <= dl_tag[CONV_LAT-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                    !(push && !pop && fifo_cnt == FC_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_f2f_share_sched.sv
// Directed and random stimulus for f2f_share_sched; a converter model drives conv_float_out and a
// transaction-level model (credit count, RR pointer, timed result queue) predicts every output.
module tb_f2f_share_sched;
    localparam int N   = 4;
    localparam int FW  = 43;
    localparam int LAT = 6;
    localparam int DEP = 8;
    localparam int TW  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [FW-1:0] conv_fixed_in;
    logic [15:0]   conv_float_out;
    logic          busy;

    f2f_share_sched_if #(.N_REQ(N), .F_WIDTH(FW), .TAG_W(TW)) bus ();

    f2f_share_sched #(.N_REQ(N), .F_WIDTH(FW), .CONV_LAT(LAT), .FIFO_DEPTH(DEP), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .conv_fixed_in(conv_fixed_in), .conv_float_out(conv_float_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Fixed-point with 10 fractional bits to half float, truncating, saturating to infinity.
    function automatic logic [15:0] fx2h(input logic [FW-1:0] x);
        logic [FW-1:0] m;
        logic [FW-1:0] mn;
        int p;
        int e;
        m = x[FW-1] ? (~x + 43'd1) : x;
        if (m == '0) return 16'h0000;
        p = 0;
        for (int i = 0; i < FW; i++) if (m[i]) p = i;
        e = p + 5;
        if (e > 30) return {x[FW-1], 5'h1F, 10'h000};
        mn = (p >= 10) ? (m >> (p - 10)) : (m << (10 - p));
        return {x[FW-1], 5'(e), mn[9:0]};
    endfunction

    // Converter: fixed pipeline, result for the input registered at E0 is sampled at E0+LAT.
    logic [15:0] cpipe [LAT-1];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT - 1; i++) cpipe[i] <= 16'h0000;
        end else begin
            cpipe[0] <= fx2h(conv_fixed_in);
            for (int i = 1; i < LAT - 1; i++) cpipe[i] <= cpipe[i-1];
        end
    end
    assign conv_float_out = cpipe[LAT-2];

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0]   q_dat [$];
    logic [TW-1:0] q_tag [$];
    int            q_time[$];
    int            outstanding = 0;
    int            rr = 0;
    int            cyc = 0;
    logic [FW-1:0] exp_conv = '0;

    logic [15:0]   obs_dat [$];
    logic [TW-1:0] obs_tag [$];
    logic          s_vld;
    logic [15:0]   s_dat;
    logic [TW-1:0] s_tag;
    int            n_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd_fx();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r = r >> $urandom_range(20, 63);
        if ($urandom_range(0, 1) == 1) return -r[FW-1:0];
        return r[FW-1:0];
    endfunction

    task automatic set_data(input int i, input logic [FW-1:0] v);
        bus.req_data[i*FW +: FW] = v;
    endtask

    // One cycle: check all outputs against the model at the negedge, then advance the model.
    task automatic tick();
        logic [N-1:0] eg;
        bit           found;
        bit           ev;
        int           w;
        int           idx;
        @(negedge clk);
        eg = '0; found = 0; w = 0;
        if (reset_n && outstanding < DEP) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr + k) % N;
                if (!found && bus.req_valid[idx]) begin found = 1; w = idx; end
            end
        end
        if (found) eg[w] = 1'b1;
        ev = (q_dat.size() > 0) && (q_time[0] <= cyc);
        chk("req_ready", 64'(bus.req_ready), 64'(eg));
        chk("res_valid", 64'(bus.res_valid), 64'(ev));
        if (ev) begin
            chk("res_data", 64'(bus.res_data), 64'(q_dat[0]));
            chk("res_tag", 64'(bus.res_tag), 64'(q_tag[0]));
        end
        chk("busy", 64'(busy), 64'(outstanding != 0));
        chk("conv_fixed_in", 64'(conv_fixed_in), 64'(exp_conv));
        s_vld = bus.res_valid; s_dat = bus.res_data; s_tag = bus.res_tag;
        if (|(bus.req_valid & bus.req_ready)) n_acc++;
        if (ev && bus.res_ready) begin
            obs_dat.push_back(s_dat); obs_tag.push_back(s_tag);
            void'(q_dat.pop_front()); void'(q_tag.pop_front()); void'(q_time.pop_front());
            outstanding--;
        end
        if (found) begin
            q_dat.push_back(fx2h(bus.req_data[w*FW +: FW]));
            q_tag.push_back(TW'(w));
            q_time.push_back(cyc + LAT + 1);
            outstanding++;
            rr = (w + 1) % N;
            exp_conv = bus.req_data[w*FW +: FW];
        end else begin
            exp_conv = '0;
        end
        if (!reset_n) begin
            q_dat.delete(); q_tag.delete(); q_time.delete();
            outstanding = 0; rr = 0; exp_conv = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        n = 0;
        while (outstanding != 0 && n < bound) begin tick(); n++; end
        chk("drain_done", 64'(outstanding == 0), 64'd1);
    endtask

    initial begin
        int lat;
        bit seen;
        int a0;
        logic [15:0]   l_dat;
        logic [TW-1:0] l_tag;

        reset_n       = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", 64'(bus.res_data), 64'd0);
        chk("rst_res_tag", 64'(bus.res_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_conv", 64'(conv_fixed_in), 64'd0);
        @(posedge clk); #1;
        reset_n       = 1'b1;
        bus.req_valid = '0;

        // Single request from requester 2: 1.0 -> 3C00 after CONV_LAT+1 cycles.
        bus.res_ready = 1'b1;
        set_data(2, 43'h0000_0000_400);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        lat = 0; seen = 0; l_dat = '0; l_tag = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!seen && s_vld) begin seen = 1; lat = i; l_dat = s_dat; l_tag = s_tag; end
        end
        chk("single_latency", 64'(lat), 64'd7);
        chk("single_data", 64'(l_dat), 64'h3C00);
        chk("single_tag", 64'(l_tag), 64'd2);

        // Reset with three samples in flight: nothing from before may surface.
        for (int i = 0; i < N; i++) set_data(i, rnd_fx());
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a0 = obs_dat.size();
        repeat (20) tick();
        chk("post_rst_no_result", 64'(obs_dat.size() - a0), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Round-robin with all requesters active.
        obs_tag.delete(); obs_dat.delete();
        bus.req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) set_data(i, rnd_fx());
            tick();
        end
        drain(40);
        chk("rr_count", 64'(obs_tag.size()), 64'd12);
        for (int i = 0; i < obs_tag.size() && i < 12; i++)
            chk("rr_tag_seq", 64'(obs_tag[i]), 64'(i % N));

        // Backpressure: FIFO fills to exactly DEP, then drains in order and streaming resumes.
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0001;
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin set_data(0, rnd_fx()); tick(); end
        chk("bp_accepts", 64'(n_acc - a0), 64'(DEP));
        chk("bp_full_valid", 64'(s_vld), 64'd1);
        bus.res_ready = 1'b1;
        a0 = n_acc;
        for (int c = 0; c < 20; c++) begin set_data(0, rnd_fx()); tick(); end
        chk("bp_resume_accepts", 64'(n_acc - a0), 64'd19);
        drain(40);

        // Negative one and zero.
        obs_dat.delete(); obs_tag.delete();
        set_data(1, 43'h7FF_FFFF_FC00);
        bus.req_valid = 4'b0010;
        tick();
        set_data(3, 43'h0);
        bus.req_valid = 4'b1000;
        tick();
        drain(40);
        chk("neg_zero_count", 64'(obs_dat.size()), 64'd2);
        if (obs_dat.size() == 2) begin
            chk("neg_one_data", 64'(obs_dat[0]), 64'hBC00);
            chk("neg_one_tag", 64'(obs_tag[0]), 64'd1);
            chk("zero_data", 64'(obs_dat[1]), 64'h0000);
            chk("zero_tag", 64'(obs_tag[1]), 64'd3);
        end

        // Random traffic with the consumer alternating between stalled, bursty and free-running.
        begin
            int pr;
            pr = 100;
            for (int c = 0; c < 1000; c++) begin
                if (c % 50 == 0) begin
                    case ($urandom_range(0, 4))
                        0: pr = 0;
                        1: pr = 10;
                        2: pr = 50;
                        3: pr = 90;
                        default: pr = 100;
                    endcase
                end
                bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
                for (int i = 0; i < N; i++) set_data(i, rnd_fx());
                bus.res_ready = ($urandom_range(0, 99) < pr);
                tick();
            end
        end
        drain(60);
        chk("final_empty", 64'(q_dat.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
